// File: rtl/seg7_scan_controller.sv
// rtl/seg7_scan_controller.sv - time-multiplexed scan controller for common-cathode 7-segment digits
//
// Purpose:
//   Holds a packed hex value and lights one digit at a time on a shared
//   segment bus. Each digit stays lit for DWELL cycles. Between digits all
//   digits are dark for BLANK cycles. New values are committed only while
//   idle or at a frame boundary, so a frame never mixes old and new digits.
//
// Optional build macro:
//   SEG7_LEADING_ZERO_BLANK_EN - when defined, blanks leading zero digits.
//   Digit 0 is always shown.
//
// Parameters:
//   DIGITS - number of digits scanned (1..8)
//   DWELL  - clk cycles each digit is lit (>= 1)
//   BLANK  - clk cycles all digits are dark between digits (>= 0)
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          synchronous reset, active-high
//   i_en           scan enable; 0 blanks the display and parks the scan
//   i_load         one-cycle strobe that captures i_value
//   i_value        packed nibbles; i_value[3:0] is digit 0 (rightmost)
//   o_seg          segments {a,b,c,d,e,f,g}; 1 = lit
//   o_dig_n        active-low digit selects; o_dig_n[i] drives digit i
//   o_frame_done   one-cycle pulse marking the end of each full frame

module seg7_scan_controller #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 50000,
  parameter int BLANK  = 500
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_value,
  output logic [6:0]            o_seg,
  output logic [DIGITS-1:0]     o_dig_n,
  output logic                  o_frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(DWELL + BLANK + 1);

  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? (BLANK - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t              r_state;
  logic [IW-1:0]       r_idx;
  logic [CW-1:0]       r_cnt;
  logic [4*DIGITS-1:0] r_shadow;
  logic [4*DIGITS-1:0] r_pending;
  logic                r_pending_valid;

  state_t              w_state;
  logic [IW-1:0]       w_idx;
  logic [CW-1:0]       w_cnt;
  logic                w_frame;
  logic                w_commit;
  logic [IW-1:0]       w_idx_next;
  logic [4*DIGITS-1:0] w_shadow;
  logic [4*DIGITS-1:0] w_pending;
  logic                w_pending_valid;
  logic [6:0]          w_seg;
  logic [DIGITS-1:0]   w_dig_n;

  // Hex nibble to {a,b,c,d,e,f,g}
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b1111110;
      4'h1: decode = 7'b0110000;
      4'h2: decode = 7'b1101101;
      4'h3: decode = 7'b1111001;
      4'h4: decode = 7'b0110011;
      4'h5: decode = 7'b1011011;
      4'h6: decode = 7'b1011111;
      4'h7: decode = 7'b1110000;
      4'h8: decode = 7'b1111111;
      4'h9: decode = 7'b1111011;
      4'hA: decode = 7'b1110111;
      4'hB: decode = 7'b0011111;
      4'hC: decode = 7'b1001110;
      4'hD: decode = 7'b0111101;
      4'hE: decode = 7'b1001111;
      default: decode = 7'b1000111;
    endcase
  endfunction

  function automatic logic [3:0] nibble(input logic [4*DIGITS-1:0] v,
                                        input logic [IW-1:0] i);
    nibble = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      if (i == IW'(k)) nibble = v[4*k +: 4];
    end
  endfunction

  function automatic logic [DIGITS-1:0] select_n(input logic [IW-1:0] i);
    for (int k = 0; k < DIGITS; k++) begin
      select_n[k] = (i != IW'(k));
    end
  endfunction

  // True when digit i and every more-significant digit hold zero.
  // Digit 0 never counts as a leading zero.
  function automatic logic leading_zero(input logic [4*DIGITS-1:0] v,
                                        input logic [IW-1:0] i);
    logic zero_above;
    zero_above = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if ((IW'(k) >= i) && (v[4*k +: 4] != 4'h0)) zero_above = 1'b0;
    end
    leading_zero = zero_above && (i != '0);
  endfunction

  assign w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

  // Next scan position. The frame boundary is the advance out of the last digit.
  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_cnt   = r_cnt;
    w_frame = 1'b0;
    if (!i_en) begin
      w_state = ST_IDLE;
      w_idx   = '0;
      w_cnt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state = ST_SHOW;
          w_idx   = '0;
          w_cnt   = '0;
        end
        ST_SHOW: begin
          if (r_cnt == DWELL_LAST) begin
            w_cnt = '0;
            if (BLANK == 0) begin
              w_state = ST_SHOW;
              w_idx   = w_idx_next;
              w_frame = (r_idx == IDX_LAST);
            end else begin
              w_state = ST_BLANK;
            end
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state = ST_SHOW;
            w_idx   = w_idx_next;
            w_cnt   = '0;
            w_frame = (r_idx == IDX_LAST);
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state = ST_IDLE;
          w_idx   = '0;
          w_cnt   = '0;
        end
      endcase
    end
  end

  // Load path. A load on a commit edge bypasses pending and lands in
  // shadow directly, so the value appears in the very next frame.
  always_comb begin
    w_commit        = (r_state == ST_IDLE) || w_frame;
    w_shadow        = r_shadow;
    w_pending       = r_pending;
    w_pending_valid = r_pending_valid;
    if (w_commit) begin
      if (i_load) begin
        w_shadow  = i_value;
        w_pending = i_value;
      end else if (r_pending_valid) begin
        w_shadow = r_pending;
      end
      w_pending_valid = 1'b0;
    end else if (i_load) begin
      w_pending       = i_value;
      w_pending_valid = 1'b1;
    end
  end

  // Outputs come from the next state, index and shadow. This keeps the
  // digit select and its segment pattern in step on every edge.
  always_comb begin
    w_seg   = 7'b0000000;
    w_dig_n = '1;
    if (w_state == ST_SHOW) begin
      w_dig_n = select_n(w_idx);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      w_seg = leading_zero(w_shadow, w_idx) ? 7'b0000000
                                             : decode(nibble(w_shadow, w_idx));
`else
      w_seg = decode(nibble(w_shadow, w_idx));
`endif
    end
  end

`ifndef SEG7_LEADING_ZERO_BLANK_EN
  // The helper is only needed when blanking is built in.
  logic w_lz_unused;
  assign w_lz_unused = leading_zero(w_shadow, w_idx);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_idx           <= '0;
      r_cnt           <= '0;
      r_shadow        <= '0;
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
      o_seg           <= 7'b0000000;
      o_dig_n         <= '1;
      o_frame_done    <= 1'b0;
    end else begin
      r_state         <= w_state;
      r_idx           <= w_idx;
      r_cnt           <= w_cnt;
      r_shadow        <= w_shadow;
      r_pending       <= w_pending;
      r_pending_valid <= w_pending_valid;
      o_seg           <= w_seg;
      o_dig_n         <= w_dig_n;
      o_frame_done    <= w_frame;
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb/tb_seg7_scan_controller.sv - directed self-checking bench for seg7_scan_controller

module tb_seg7_scan_controller;

  localparam int DIGITS = 4;
  localparam int DWELL  = 4;
  localparam int BLANK  = 2;

  localparam logic [6:0] S_OFF = 7'b0000000;
  localparam logic [6:0] S_0   = 7'b1111110;
  localparam logic [6:0] S_1   = 7'b0110000;
  localparam logic [6:0] S_2   = 7'b1101101;
  localparam logic [6:0] S_3   = 7'b1111001;
  localparam logic [6:0] S_4   = 7'b0110011;
  localparam logic [6:0] S_5   = 7'b1011011;
  localparam logic [6:0] S_A   = 7'b1110111;
  localparam logic [6:0] S_B   = 7'b0011111;
  localparam logic [6:0] S_C   = 7'b1001110;
  localparam logic [6:0] S_D   = 7'b0111101;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] S_LZ  = 7'b0000000;
`else
  localparam logic [6:0] S_LZ  = 7'b1111110;
`endif

  localparam logic [3:0] D0 = 4'b1110;
  localparam logic [3:0] D1 = 4'b1101;
  localparam logic [3:0] D2 = 4'b1011;
  localparam logic [3:0] D3 = 4'b0111;
  localparam logic [3:0] DX = 4'b1111;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic                load;
  logic [4*DIGITS-1:0] value;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   dig_n;
  logic                frame_done;

  int n_cmp  = 0;
  int n_fail = 0;

  seg7_scan_controller #(
    .DIGITS(DIGITS),
    .DWELL (DWELL),
    .BLANK (BLANK)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_load       (load),
    .i_value      (value),
    .o_seg        (seg),
    .o_dig_n      (dig_n),
    .o_frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] dn,
                       input logic [6:0] sg, input logic fd);
    n_cmp++;
    assert ({seg, dig_n, frame_done} === {sg, dn, fd})
    else begin
      n_fail++;
      $error("FAIL %s: seg=%b dig_n=%b frame_done=%b, want seg=%b dig_n=%b frame_done=%b",
             tag, seg, dig_n, frame_done, sg, dn, fd);
    end
  endtask

  // Advance n cycles and check the outputs after each edge.
  task automatic expect_n(input string tag, input int n, input logic [3:0] dn,
                          input logic [6:0] sg, input logic fd);
    for (int c = 0; c < n; c++) begin
      tick();
      check(tag, dn, sg, (c == 0) ? fd : 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; load = 1'b1; value = 16'hFFFF;
    tick();
    tick();
    check("reset", DX, S_OFF, 1'b0);

    rst = 1'b0; en = 1'b0; load = 1'b0;
    expect_n("idle_after_reset", 3, DX, S_OFF, 1'b0);

    load = 1'b1; value = 16'h1234;
    expect_n("load_in_idle", 1, DX, S_OFF, 1'b0);
    load = 1'b0; en = 1'b1;
    expect_n("f1_d0", DWELL, D0, S_4, 1'b0);
    expect_n("f1_b0", BLANK, DX, S_OFF, 1'b0);
    expect_n("f1_d1", DWELL, D1, S_3, 1'b0);
    expect_n("f1_b1", BLANK, DX, S_OFF, 1'b0);
    expect_n("f1_d2", DWELL, D2, S_2, 1'b0);
    expect_n("f1_b2", BLANK, DX, S_OFF, 1'b0);
    expect_n("f1_d3", DWELL, D3, S_1, 1'b0);
    expect_n("f1_b3", BLANK, DX, S_OFF, 1'b0);
    expect_n("f2_d0_frame_done", DWELL, D0, S_4, 1'b1);
    expect_n("f2_b0", BLANK, DX, S_OFF, 1'b0);

    load = 1'b1; value = 16'hABCD;
    expect_n("f2_d1_load", 1, D1, S_3, 1'b0);
    load = 1'b0;
    expect_n("f2_d1_old", DWELL - 1, D1, S_3, 1'b0);
    expect_n("f2_b1", BLANK, DX, S_OFF, 1'b0);
    expect_n("f2_d2_old", DWELL, D2, S_2, 1'b0);
    expect_n("f2_b2", BLANK, DX, S_OFF, 1'b0);
    expect_n("f2_d3_old", DWELL, D3, S_1, 1'b0);
    expect_n("f2_b3", BLANK, DX, S_OFF, 1'b0);
    expect_n("f3_d0_new", 2, D0, S_D, 1'b1);

    en = 1'b0;
    expect_n("en_drop", 3, DX, S_OFF, 1'b0);
    en = 1'b1;
    expect_n("reenable_d0", DWELL, D0, S_D, 1'b0);
    expect_n("re_b0", BLANK, DX, S_OFF, 1'b0);
    expect_n("re_d1", DWELL, D1, S_C, 1'b0);
    expect_n("re_b1", BLANK, DX, S_OFF, 1'b0);
    expect_n("re_d2", DWELL, D2, S_B, 1'b0);
    expect_n("re_b2", BLANK, DX, S_OFF, 1'b0);
    expect_n("re_d3", DWELL, D3, S_A, 1'b0);
    expect_n("re_b3", BLANK, DX, S_OFF, 1'b0);

    load = 1'b1; value = 16'h2345;
    expect_n("boundary_load_d0", 1, D0, S_5, 1'b1);
    load = 1'b0;
    expect_n("bl_d0", DWELL - 1, D0, S_5, 1'b0);
    expect_n("bl_b0", BLANK, DX, S_OFF, 1'b0);
    expect_n("bl_d1", DWELL, D1, S_4, 1'b0);
    expect_n("bl_b1", BLANK, DX, S_OFF, 1'b0);
    expect_n("bl_d2", DWELL, D2, S_3, 1'b0);

    load = 1'b1; value = 16'h9999;
    expect_n("bl_b2_pending", 1, DX, S_OFF, 1'b0);
    load = 1'b0; rst = 1'b1;
    expect_n("rst_mid_blank", 1, DX, S_OFF, 1'b0);
    rst = 1'b0;
    expect_n("post_rst_d0", 1, D0, S_0, 1'b0);
    en = 1'b0;
    expect_n("post_rst_idle", 1, DX, S_OFF, 1'b0);

    load = 1'b1; value = 16'h0050;
    expect_n("lz_load", 1, DX, S_OFF, 1'b0);
    load = 1'b0; en = 1'b1;
    expect_n("lz_d0", DWELL, D0, S_0, 1'b0);
    expect_n("lz_b0", BLANK, DX, S_OFF, 1'b0);
    expect_n("lz_d1", DWELL, D1, S_5, 1'b0);
    expect_n("lz_b1", BLANK, DX, S_OFF, 1'b0);
    expect_n("lz_d2", DWELL, D2, S_LZ, 1'b0);
    expect_n("lz_b2", BLANK, DX, S_OFF, 1'b0);
    expect_n("lz_d3", DWELL, D3, S_LZ, 1'b0);
    expect_n("lz_b3", BLANK, DX, S_OFF, 1'b0);
    expect_n("lz_wrap_d0", 1, D0, S_0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
